// File: rtl/pacoblaze_register_stage.sv
// Register file and operand stage: latches ALU operands on issue, owns the
// write-back path with same-edge bypass, and keeps the zero/carry flags plus
// their interrupt shadow copies.
module pacoblaze_register_stage #(
  parameter int unsigned operand_width  = 8,
  parameter int unsigned register_count = 16,
  localparam int unsigned address_width = $clog2(register_count)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     issue,
  input  logic [address_width-1:0] x_address,
  input  logic [address_width-1:0] y_address,
  input  logic                     use_constant,
  input  logic [operand_width-1:0] constant,
  output logic [operand_width-1:0] operand_a,
  output logic [operand_width-1:0] operand_b,
  output logic                     operand_valid,
  input  logic                     write_enable,
  input  logic [operand_width-1:0] write_result,
  input  logic                     flags_update,
  input  logic                     zero_in,
  input  logic                     carry_in,
  input  logic                     flags_preserve,
  input  logic                     flags_restore,
  output logic                     zero,
  output logic                     carry
);

  logic [operand_width-1:0] regs [register_count];
  logic [address_width-1:0] dest_q;
  logic                     shadow_zero_q;
  logic                     shadow_carry_q;
  logic [operand_width-1:0] next_a;
  logic [operand_width-1:0] next_b;

  // Operand selection; a write landing on the same edge is bypassed so the
  // operand sees the value the register is about to hold.
  always_comb begin
    next_a = regs[x_address];
    next_b = regs[y_address];
    if (write_enable && (dest_q == x_address)) next_a = write_result;
    if (write_enable && (dest_q == y_address)) next_b = write_result;
    if (use_constant) next_b = constant;
  end

  // Register file write port; contents survive reset, but a write on a reset
  // edge is dropped. The target is the destination captured by the previous issue.
  always_ff @(posedge clk) begin
    if (!reset && write_enable) begin
      regs[dest_q] <= write_result;
    end
  end

  // Destination latch and operand registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      dest_q        <= '0;
      operand_a     <= '0;
      operand_b     <= '0;
      operand_valid <= 1'b0;
    end else begin
      operand_valid <= issue;
      if (issue) begin
        dest_q    <= x_address;
        operand_a <= next_a;
        operand_b <= next_b;
      end
    end
  end

  // Architectural flags: restore beats update; preserve captures pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      zero           <= 1'b0;
      carry          <= 1'b0;
      shadow_zero_q  <= 1'b0;
      shadow_carry_q <= 1'b0;
    end else begin
      if (flags_restore) begin
        zero  <= shadow_zero_q;
        carry <= shadow_carry_q;
      end else if (flags_update) begin
        zero  <= zero_in;
        carry <= carry_in;
      end
      if (flags_preserve) begin
        shadow_zero_q  <= zero;
        shadow_carry_q <= carry;
      end
    end
  end

endmodule

// File: doc/pacoblaze_register_stage.md
PACOBLAZE_REGISTER_STAGE -- requirements
Module: pacoblaze_register_stage

Interface
REQ-001 SHALL provide parameter operand_width, default 8, meaning the register and operand width in bits.
REQ-002 SHALL provide parameter register_count, default 16, meaning the number of registers; the address width is log2(register_count), 4 at default.
REQ-003 SHALL have port clk  input  1  meaning the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  meaning the reset; it is synchronous and active-high.
REQ-005 SHALL have port issue  input  1  meaning the instruction-issue strobe.
REQ-006 SHALL have ports x_address and y_address  input  4  meaning the sX and sY register addresses.
REQ-007 SHALL have ports use_constant (input, 1) and constant (input, 8), meaning operand_b is taken from constant instead of sY.
REQ-008 SHALL have ports operand_a and operand_b  output  8  meaning the ALU operands, registered.
REQ-009 SHALL have port operand_valid  output  1  meaning operand_a and operand_b are valid.
REQ-010 SHALL have ports write_enable (input, 1) and write_result (input, 8), meaning the ALU result writeback.
REQ-011 SHALL have ports flags_update, zero_in and carry_in  input  1 each, driven by the ALU zero_out and carry_out.
REQ-012 SHALL have ports flags_preserve and flags_restore  input  1 each, meaning interrupt entry and RETURNI respectively.
REQ-013 SHALL have ports zero and carry  output  1 each, meaning the architectural flags; carry feeds the ALU carry_in.

Function
REQ-014 SHALL implement the register file as register_count x operand_width storage with two combinational read ports and one synchronous write port.
REQ-015 SHALL, on an edge with issue=1, capture x_address into a destination latch and load the operand registers: operand_a gets reg[x_address]; operand_b gets constant if use_constant=1, otherwise reg[y_address].
REQ-016 SHALL assert operand_valid for exactly the one cycle following each issue edge; back-to-back issues keep it high continuously.
REQ-017 SHALL hold operand_a and operand_b unchanged when issue=0.
REQ-018 SHALL, on an edge with write_enable=1, write write_result to the register at the destination latch value held before that edge.
REQ-019 SHALL, when issue and write_enable are both 1 on the same edge, write to the old destination and then update the destination latch to the new x_address.
REQ-020 SHALL forward write_result into operand_a or operand_b when, on the same edge, write_enable=1 and the write target equals the corresponding read address; a selected constant is never overridden.
REQ-021 SHALL, on an edge with flags_update=1, load zero from zero_in and carry from carry_in; otherwise the flags hold.
REQ-022 SHALL, on an edge with flags_preserve=1, copy the current zero and carry (the pre-edge values) into the shadow flags.
REQ-023 SHALL, on an edge with flags_restore=1, load zero and carry from the shadow flags.
REQ-024 SHALL give flags_restore priority over flags_update when both are asserted; flags_preserve with flags_update saves the pre-update values.
REQ-025 SHALL make the destination latch and write path wrap-free: every address 0..register_count-1 is valid, and out-of-range values do not exist at default width.

Reset
REQ-026 SHALL, on an edge with reset=1, clear operand_a, operand_b, operand_valid, zero, carry, the shadow flags and the destination latch to 0.
REQ-027 SHALL give reset priority over issue, write_enable and every flag input on the same edge; such writes are discarded.
REQ-028 SHALL NOT clear the register file contents on reset.

Verification
REQ-029 SHALL be checked with this directed scenario: write 0x5A to s3; issue x=3, y=4 with use_constant=1 and constant=0x11 -> next cycle operand_a=0x5A, operand_b=0x11, operand_valid=1 for one cycle.
REQ-030 SHALL be checked with this directed scenario: an issue with x=2 is followed by write_enable with 0x77 together with a new issue of y=2 -> operand_b=0x77 (bypass), and s2 later reads 0x77.
REQ-031 SHALL be checked with this directed scenario: set the flags to Z=1, C=0; apply preserve and update (zero_in=0, carry_in=1) together -> Z=0, C=1; then apply restore -> Z=1, C=0.
REQ-032 SHALL be checked with this directed scenario: apply restore and update on the same edge -> the flags equal the shadow values.
REQ-033 SHALL be checked with this directed scenario: apply reset together with issue and write_enable -> all outputs are 0, operand_valid=0, and the target register is unchanged.
REQ-034 SHALL be checked with this directed scenario: issue every cycle for 16 cycles across addresses 0..15 -> operand_valid stays 1 and each operand matches the preloaded pattern.
